// File: rtl/mgmt_smbus_echo_pkg.sv
// Shared types and helpers for the multi-channel SMBus echo arbiter.
package mgmt_smbus_echo_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    START  = 4'd1,
    STOP   = 4'd2,
    BIT0   = 4'd3,
    BIT1   = 4'd4,
    ACK    = 4'd5,
    NACK   = 4'd6,
    RSTART = 4'd7
  } smbus_evt_e;

  localparam int DEFAULT_TIMEOUT = 64;

  // A single channel still needs a one-bit index port.
  function automatic int ch_idx_w(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mgmt_smbus_echo_fifo.sv
// Per-channel event FIFO: single clock, synchronous flush, power-of-2 depth.
module mgmt_smbus_echo_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  // A simultaneous pop frees the slot, so a full FIFO may still take a push.
  assign push_ok = push && (!full || pop) && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mgmt_smbus_echo_arb.sv
// Round-robin arbiter of per-channel SMBus relay events into LTPI frame slots,
// with per-channel echo tracking (match, mismatch/stray, timeout).
module mgmt_smbus_echo_arb
  import mgmt_smbus_echo_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int EVT_W      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int CH_W      = ch_idx_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_CH-1:0]       ch_en,
  input  logic [N_CH-1:0]       echo_en,
  input  logic [N_CH-1:0]       loc_evt_valid,
  input  logic [N_CH*EVT_W-1:0] loc_evt,
  output logic [N_CH-1:0]       loc_evt_ready,
  input  logic                  frm_tick,
  output logic                  tx_valid,
  output logic [CH_W-1:0]       tx_ch,
  output logic [EVT_W-1:0]      tx_evt,
  input  logic                  rx_valid,
  input  logic [CH_W-1:0]       rx_ch,
  input  logic [EVT_W-1:0]      rx_evt,
  output logic [N_CH-1:0]       outstanding,
  output logic [N_CH-1:0]       err_timeout,
  output logic [N_CH-1:0]       err_mismatch,
  input  logic [N_CH-1:0]       err_clr
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [N_CH-1:0]  fifo_empty;
  logic [N_CH-1:0]  fifo_full;
  logic [N_CH-1:0]  push;
  logic [N_CH-1:0]  pop;
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  rx_hit;
  logic [N_CH-1:0]  rx_match;
  logic [N_CH-1:0]  mismatch_set;
  logic [N_CH-1:0]  timeout_set;
  logic [EVT_W-1:0] fifo_dout [N_CH];
  logic [EVT_W-1:0] exp_evt   [N_CH];
  logic [TW-1:0]    timer     [N_CH];
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  grant_idx;
  logic             grant_any;
  logic             grant;

  assign loc_evt_ready = ch_en & ~fifo_full;
  assign push          = loc_evt_valid & loc_evt_ready;
  assign eligible      = ch_en & ~fifo_empty & ~(echo_en & outstanding);
  assign grant         = frm_tick && grant_any;

  for (genvar g = 0; g < N_CH; g++) begin : g_fifo
    mgmt_smbus_echo_fifo #(
      .W    (EVT_W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .flush  (~ch_en[g]),
      .push   (push[g]),
      .din    (loc_evt[g*EVT_W +: EVT_W]),
      .pop    (pop[g]),
      .dout   (fifo_dout[g]),
      .empty  (fifo_empty[g]),
      .full   (fifo_full[g])
    );
  end

  // First eligible channel at or after the pointer, wrapping once.
  always_comb begin
    int j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      if (!grant_any && eligible[CH_W'(j)]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(j);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (grant) pop[grant_idx] = 1'b1;
  end

  // An rx in the timer's last cycle resolves the echo before the timeout fires.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rx_hit[i]       = rx_valid && (rx_ch == CH_W'(i));
      rx_match[i]     = rx_hit[i] && outstanding[i] && (rx_evt == exp_evt[i]);
      mismatch_set[i] = rx_hit[i] && !rx_match[i];
      timeout_set[i]  = ch_en[i] && outstanding[i] && !rx_hit[i] && (timer[i] == TW'(1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr       <= '0;
      tx_valid     <= 1'b0;
      tx_ch        <= '0;
      tx_evt       <= '0;
      outstanding  <= '0;
      err_timeout  <= '0;
      err_mismatch <= '0;
      for (int i = 0; i < N_CH; i++) begin
        timer[i]   <= '0;
        exp_evt[i] <= '0;
      end
    end else begin
      tx_valid <= grant;
      if (grant) begin
        tx_ch  <= grant_idx;
        tx_evt <= fifo_dout[grant_idx];
        rr_ptr <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
      for (int i = 0; i < N_CH; i++) begin
        err_timeout[i]  <= (err_timeout[i]  & ~err_clr[i]) | timeout_set[i];
        err_mismatch[i] <= (err_mismatch[i] & ~err_clr[i]) | mismatch_set[i];
        if (!ch_en[i]) begin
          outstanding[i] <= 1'b0;
          timer[i]       <= '0;
        end else if (pop[i] && echo_en[i]) begin
          outstanding[i] <= 1'b1;
          exp_evt[i]     <= fifo_dout[i];
          timer[i]       <= TW'(TIMEOUT);
        end else if (rx_hit[i] || timeout_set[i]) begin
          outstanding[i] <= 1'b0;
          timer[i]       <= '0;
        end else if (outstanding[i]) begin
          timer[i] <= timer[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mgmt_smbus_echo_arb.sv
// Directed bench for mgmt_smbus_echo_arb: arbitration order, echo tracking, flush and reset.
module tb_mgmt_smbus_echo_arb;
  import mgmt_smbus_echo_pkg::*;

  localparam int N_CH = 4, EVT_W = 4, FIFO_DEPTH = 4, TIMEOUT = 64, CH_W = 2;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [N_CH-1:0]       ch_en = '0, echo_en = '0, loc_evt_valid = '0, err_clr = '0;
  logic [N_CH*EVT_W-1:0] loc_evt = '0;
  logic                  frm_tick = 1'b0, rx_valid = 1'b0;
  logic [CH_W-1:0]       rx_ch = '0;
  logic [EVT_W-1:0]      rx_evt = '0;
  logic [N_CH-1:0]       loc_evt_ready, outstanding, err_timeout, err_mismatch;
  logic                  tx_valid;
  logic [CH_W-1:0]       tx_ch;
  logic [EVT_W-1:0]      tx_evt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mgmt_smbus_echo_arb #(
    .N_CH(N_CH), .EVT_W(EVT_W), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ch_en(ch_en), .echo_en(echo_en),
    .loc_evt_valid(loc_evt_valid), .loc_evt(loc_evt), .loc_evt_ready(loc_evt_ready),
    .frm_tick(frm_tick), .tx_valid(tx_valid), .tx_ch(tx_ch), .tx_evt(tx_evt),
    .rx_valid(rx_valid), .rx_ch(rx_ch), .rx_evt(rx_evt), .outstanding(outstanding),
    .err_timeout(err_timeout), .err_mismatch(err_mismatch), .err_clr(err_clr)
  );

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_evts(input logic [N_CH-1:0] mask, input logic [N_CH*EVT_W-1:0] evts);
    loc_evt_valid = mask;
    loc_evt       = evts;
    step();
    loc_evt_valid = '0;
  endtask

  // Leaves the caller in the cycle where tx_valid for this tick is visible.
  task automatic do_tick(output logic v, output logic [CH_W-1:0] c, output logic [EVT_W-1:0] e);
    frm_tick = 1'b1;
    step();
    frm_tick = 1'b0;
    v = tx_valid;
    c = tx_ch;
    e = tx_evt;
  endtask

  task automatic send_rx(input logic [CH_W-1:0] c, input logic [EVT_W-1:0] e);
    rx_valid = 1'b1;
    rx_ch    = c;
    rx_evt   = e;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    step(2);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
    checks++; if (outstanding !== 4'h0) begin errors++; $display("FAIL reset_outstanding: got %h expected 0", outstanding); end
    checks++; if (err_timeout !== 4'h0) begin errors++; $display("FAIL reset_err_timeout: got %h expected 0", err_timeout); end
    checks++; if (err_mismatch !== 4'h0) begin errors++; $display("FAIL reset_err_mismatch: got %h expected 0", err_mismatch); end
    checks++; if (loc_evt_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %h expected 0", loc_evt_ready); end
    reset_n = 1'b1;
    ch_en   = 4'hF;
    step();
    checks++; if (loc_evt_ready !== 4'hF) begin errors++; $display("FAIL ready_after_enable: got %h expected f", loc_evt_ready); end
  endtask

  task automatic test_round_robin();
    logic [CH_W-1:0]  exp_ch  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [EVT_W-1:0] exp_evt [8] = '{START, BIT0, ACK, RSTART, STOP, BIT1, NACK, IDLE};
    logic v;
    logic [CH_W-1:0] c;
    logic [EVT_W-1:0] e;
    echo_en = 4'h0;
    push_evts(4'hF, {RSTART, ACK, BIT0, START});
    push_evts(4'hF, {IDLE, NACK, BIT1, STOP});
    for (int n = 0; n < 8; n++) begin
      do_tick(v, c, e);
      checks++; if (v !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", n, v); end
      checks++; if (c !== exp_ch[n]) begin errors++; $display("FAIL rr_ch[%0d]: got %0d expected %0d", n, c, exp_ch[n]); end
      checks++; if (e !== exp_evt[n]) begin errors++; $display("FAIL rr_evt[%0d]: got %0d expected %0d", n, e, exp_evt[n]); end
      step();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rr_one_cycle[%0d]: got %b expected 0", n, tx_valid); end
    end
    do_tick(v, c, e);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rr_empty_tick: got %b expected 0", v); end
  endtask

  task automatic test_echo_match();
    logic v;
    logic [CH_W-1:0] c;
    logic [EVT_W-1:0] e;
    echo_en = 4'b0100;
    push_evts(4'b0100, {4'h0, BIT1, 8'h00});
    push_evts(4'b0100, {4'h0, BIT0, 8'h00});
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd2, BIT1}) begin errors++; $display("FAIL echo_tx: got %b/%0d/%0d expected 1/2/%0d", v, c, e, BIT1); end
    checks++; if (outstanding !== 4'b0100) begin errors++; $display("FAIL echo_outstanding_set: got %h expected 4", outstanding); end
    do_tick(v, c, e);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL echo_blocked: got %b expected 0", v); end
    step(8);
    send_rx(2'd2, BIT1);
    checks++; if (outstanding !== 4'h0) begin errors++; $display("FAIL echo_cleared: got %h expected 0", outstanding); end
    checks++; if ({err_timeout, err_mismatch} !== 8'h00) begin errors++; $display("FAIL echo_no_err: got %h expected 00", {err_timeout, err_mismatch}); end
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd2, BIT0}) begin errors++; $display("FAIL echo_second_tx: got %b/%0d/%0d expected 1/2/%0d", v, c, e, BIT0); end
    send_rx(2'd2, BIT0);
    checks++; if (outstanding !== 4'h0) begin errors++; $display("FAIL echo_second_clear: got %h expected 0", outstanding); end
  endtask

  task automatic test_mismatch_stray();
    logic v;
    logic [CH_W-1:0] c;
    logic [EVT_W-1:0] e;
    echo_en = 4'b0110;
    push_evts(4'b0010, {8'h00, ACK, 4'h0});
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd1, ACK}) begin errors++; $display("FAIL mm_tx: got %b/%0d/%0d expected 1/1/%0d", v, c, e, ACK); end
    send_rx(2'd1, NACK);
    checks++; if (err_mismatch !== 4'b0010) begin errors++; $display("FAIL mm_set: got %h expected 2", err_mismatch); end
    checks++; if (outstanding !== 4'h0) begin errors++; $display("FAIL mm_outstanding: got %h expected 0", outstanding); end
    send_rx(2'd3, ACK);
    checks++; if (err_mismatch !== 4'b1010) begin errors++; $display("FAIL stray_set: got %h expected a", err_mismatch); end
    checks++; if (err_timeout !== 4'h0) begin errors++; $display("FAIL mm_no_timeout: got %h expected 0", err_timeout); end
    err_clr = 4'b1010;
    step();
    err_clr = 4'h0;
    checks++; if (err_mismatch !== 4'h0) begin errors++; $display("FAIL mm_clear: got %h expected 0", err_mismatch); end
    // A stray echo landing on the same cycle as the clear must stay set.
    err_clr = 4'b1000;
    send_rx(2'd3, ACK);
    err_clr = 4'h0;
    checks++; if (err_mismatch !== 4'b1000) begin errors++; $display("FAIL set_beats_clear: got %h expected 8", err_mismatch); end
    err_clr = 4'b1000;
    step();
    err_clr = 4'h0;
    checks++; if (err_mismatch !== 4'h0) begin errors++; $display("FAIL mm_clear2: got %h expected 0", err_mismatch); end
  endtask

  task automatic test_timeout();
    logic v;
    logic [CH_W-1:0] c;
    logic [EVT_W-1:0] e;
    echo_en = 4'b0001;
    push_evts(4'b0001, {12'h000, START});
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd0, START}) begin errors++; $display("FAIL to_tx: got %b/%0d/%0d expected 1/0/%0d", v, c, e, START); end
    step(TIMEOUT - 1);
    checks++; if ({outstanding[0], err_timeout[0]} !== 2'b10) begin errors++; $display("FAIL to_before: got out=%b err=%b expected 1/0", outstanding[0], err_timeout[0]); end
    step();
    checks++; if (err_timeout !== 4'b0001) begin errors++; $display("FAIL to_fire: got %h expected 1", err_timeout); end
    checks++; if (outstanding !== 4'h0) begin errors++; $display("FAIL to_outstanding: got %h expected 0", outstanding); end
    err_clr = 4'b0001;
    step();
    err_clr = 4'h0;
    checks++; if (err_timeout !== 4'h0) begin errors++; $display("FAIL to_clear: got %h expected 0", err_timeout); end
    push_evts(4'b0001, {12'h000, STOP});
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd0, STOP}) begin errors++; $display("FAIL to_tx2: got %b/%0d/%0d expected 1/0/%0d", v, c, e, STOP); end
    // Echo arrives in the last cycle the timer still holds the channel.
    step(TIMEOUT - 1);
    send_rx(2'd0, STOP);
    checks++; if (err_timeout !== 4'h0) begin errors++; $display("FAIL to_rx_last: got %h expected 0", err_timeout); end
    checks++; if ({outstanding, err_mismatch} !== 8'h00) begin errors++; $display("FAIL to_rx_last_state: got %h expected 00", {outstanding, err_mismatch}); end
    step(3);
    checks++; if (err_timeout !== 4'h0) begin errors++; $display("FAIL to_rx_last_later: got %h expected 0", err_timeout); end
  endtask

  task automatic test_full_flush();
    logic v;
    logic [CH_W-1:0] c;
    logic [EVT_W-1:0] e;
    echo_en = 4'b0010;
    push_evts(4'b0010, {8'h00, BIT0, 4'h0});
    do_tick(v, c, e);
    checks++; if ({v, c} !== {1'b1, 2'd1}) begin errors++; $display("FAIL ff_tx: got %b/%0d expected 1/1", v, c); end
    checks++; if (outstanding !== 4'b0010) begin errors++; $display("FAIL ff_outstanding: got %h expected 2", outstanding); end
    for (int n = 0; n < FIFO_DEPTH - 1; n++) push_evts(4'b0010, {8'h00, BIT1, 4'h0});
    checks++; if (loc_evt_ready !== 4'hF) begin errors++; $display("FAIL ff_ready_depth_m1: got %h expected f", loc_evt_ready); end
    push_evts(4'b0010, {8'h00, BIT1, 4'h0});
    checks++; if (loc_evt_ready !== 4'b1101) begin errors++; $display("FAIL ff_full: got %h expected d", loc_evt_ready); end
    ch_en = 4'b1101;
    step();
    checks++; if (outstanding !== 4'h0) begin errors++; $display("FAIL ff_flush_outstanding: got %h expected 0", outstanding); end
    checks++; if ({err_timeout, err_mismatch} !== 8'h00) begin errors++; $display("FAIL ff_flush_no_err: got %h expected 00", {err_timeout, err_mismatch}); end
    send_rx(2'd1, BIT0);
    checks++; if (err_mismatch !== 4'b0010) begin errors++; $display("FAIL ff_stray_after_flush: got %h expected 2", err_mismatch); end
    err_clr = 4'b0010;
    ch_en   = 4'hF;
    step();
    err_clr = 4'h0;
    checks++; if (loc_evt_ready !== 4'hF) begin errors++; $display("FAIL ff_reenable_ready: got %h expected f", loc_evt_ready); end
    do_tick(v, c, e);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL ff_no_tx: got %b expected 0", v); end
  endtask

  task automatic test_reset_mid();
    logic v;
    logic [CH_W-1:0] c;
    logic [EVT_W-1:0] e;
    echo_en = 4'b0100;
    push_evts(4'b1101, {STOP, ACK, 4'h0, BIT1});
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd2, ACK}) begin errors++; $display("FAIL rm_tx: got %b/%0d/%0d expected 1/2/%0d", v, c, e, ACK); end
    frm_tick = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({tx_valid, outstanding, err_timeout, err_mismatch} !== 13'h0) begin errors++; $display("FAIL rm_async: got %h expected 0", {tx_valid, outstanding, err_timeout, err_mismatch}); end
    step(2);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rm_no_tx_in_reset: got %b expected 0", tx_valid); end
    frm_tick = 1'b0;
    reset_n  = 1'b1;
    step();
    do_tick(v, c, e);
    checks++; if (v !== 1'b0) begin errors++; $display("FAIL rm_fifos_dropped: got %b expected 0", v); end
    echo_en = 4'h0;
    push_evts(4'b1001, {RSTART, 8'h00, START});
    do_tick(v, c, e);
    checks++; if ({v, c, e} !== {1'b1, 2'd0, START}) begin errors++; $display("FAIL rm_first_grant: got %b/%0d/%0d expected 1/0/%0d", v, c, e, START); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_echo_match();
    test_mismatch_stray();
    test_timeout();
    test_full_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mgmt_smbus_echo_arb.md
Name: mgmt_smbus_echo_arb

Overview:
- Multi-channel successor to the single-channel SMBus echo-enable logic in the LTPI management path.
- Buffers SMBus relay events from N_CH local channels and arbitrates them round-robin into one LTPI frame slot per frame tick.
- When echo is enabled for a channel, it tracks the remote echo of each sent event and flags timeout or mismatch per channel.
- Sits between the per-channel SMBus relay front-ends and the LTPI management frame encoder/decoder.

Parameters:
- N_CH, 4, number of SMBus channels (1..16).
- EVT_W, 4, event code width (matches package enum).
- FIFO_DEPTH, 4, per-channel event FIFO depth (power of 2, >=2).
- TIMEOUT, 64, cycles to wait for an echo before flagging a timeout (>=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ch_en  in  N_CH  per-channel enable.
- echo_en  in  N_CH  per-channel echo-check enable.
- loc_evt_valid  in  N_CH  local event valid.
- loc_evt  in  N_CH*EVT_W  local event codes, channel i at [i*EVT_W +: EVT_W].
- loc_evt_ready  out  N_CH  FIFO can accept.
- frm_tick  in  1  one-cycle pulse marking a frame slot.
- tx_valid  out  1  event issued this cycle.
- tx_ch  out  $clog2(N_CH)  issued channel.
- tx_evt  out  EVT_W  issued event.
- rx_valid  in  1  echoed event received.
- rx_ch  in  $clog2(N_CH)  echo channel.
- rx_evt  in  EVT_W  echo event.
- outstanding  out  N_CH  echo pending.
- err_timeout  out  N_CH  sticky timeout error.
- err_mismatch  out  N_CH  sticky mismatch or stray-echo error.
- err_clr  in  N_CH  clears the sticky errors.

Behaviour:
- Reset: all outputs 0; FIFOs empty; round-robin pointer 0; timers 0.
- loc_evt_ready[i] = ch_en[i] & !full[i]. A push occurs on valid & ready.
- Eligible[i] = ch_en[i] & !empty[i] & !(echo_en[i] & outstanding[i]).
- On frm_tick with any channel eligible:
  - Grant goes to the first eligible channel at or after the pointer, with wrap-around.
  - Pop the head entry; the next cycle drives tx_valid=1, tx_ch, tx_evt for exactly one cycle.
  - The pointer moves to grant+1 mod N_CH.
- frm_tick with no eligible channel: tx_valid stays 0 and the pointer is unchanged.
- A push to a FIFO that is full is impossible (ready=0). Push and pop in the same cycle keep the count unchanged, including when the FIFO is full.
- Echo tracking, per channel:
  - When a grant occurs and echo_en[i]=1, set outstanding[i], latch the expected event, and load timer=TIMEOUT.
  - The timer decrements each cycle while outstanding.
- rx_valid for channel c:
  - If outstanding[c] and rx_evt == expected: clear outstanding.
  - If outstanding[c] and rx_evt differs: set err_mismatch[c] and clear outstanding.
  - If not outstanding[c]: set err_mismatch[c] (stray echo).
- Timer reaching 1 while outstanding with no matching rx that cycle:
  - Set err_timeout[i] and clear outstanding the next cycle.
  - The timeout is exactly TIMEOUT cycles after tx_valid.
  - rx in the final cycle takes precedence over timeout.
- echo_en deasserted while outstanding: the pending echo still resolves normally.
- ch_en[i] deasserted:
  - Synchronously flush FIFO i and clear outstanding[i]; no error is set.
  - Any rx for that channel is then treated as stray.
- Sticky errors: err_clr[i] clears them; a set in the same cycle as a clear wins.
- rx_ch >= N_CH is ignored.
- Asynchronous reset mid-transfer: all state is dropped and no tx_valid is emitted.

Decomposition:
- mgmt_smbus_echo_pkg holds:
  - typedef enum logic [3:0] smbus_evt_e: IDLE, START, STOP, BIT0, BIT1, ACK, NACK, RSTART.
  - Default TIMEOUT constant.
  - Channel-index width function.
- Sub-module mgmt_smbus_echo_fifo: single-clock synchronous FIFO with flush, instantiated N_CH times. The arbiter and echo trackers live in the top module.

Test Plan:
- Round-robin: N_CH=4, all echo_en=0, each channel preloaded with 2 events, 8 frm_ticks -> tx_ch order 0,1,2,3,0,1,2,3, with each channel's events in order.
- Echo match: ch2 echo_en=1, sends BIT1; rx (ch2, BIT1) 10 cycles later -> outstanding[2] clears and there are no errors. The second ch2 event is not granted until the echo arrives.
- Echo mismatch and stray: ch1 sends ACK and gets echo NACK -> err_mismatch[1]=1. rx on ch3 with nothing outstanding -> err_mismatch[3]=1. err_clr clears both.
- Timeout: TIMEOUT=64, ch0 sends START with no echo -> err_timeout[0] rises 64 cycles after tx_valid. An rx at exactly cycle 64 -> no timeout.
- Full and flush: with no frm_tick, push FIFO_DEPTH=4 events into ch1 -> loc_evt_ready[1]=0. Deassert ch_en[1] -> FIFO empties, outstanding clears, and no tx occurs on later ticks.
- Reset mid-operation: assert reset_n low while outstanding and FIFOs are non-empty -> all outputs 0 immediately. After release, the first grant goes to channel 0.
